// File: rtl/pipeline_arbiter.sv
// Round-robin arbiter feeding a single stall-able output entry register, with
// per-ID flush that both drops a matching held entry and masks matching requesters.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module pipeline_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int AW      = `ADDRESS_WIDTH,
   parameter int IW      = `ID_WIDTH,
   parameter int GW      = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ*AW-1:0] req_address,
   input  logic [NUM_REQ*IW-1:0] req_id,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic                  flush_in,
   input  logic [IW-1:0]         flush_id_in,
   output logic [AW-1:0]         pipe_address,
   output logic [IW-1:0]         pipe_id,
   output logic                  pipe_valid,
   input  logic                  pipe_stall,
   output logic                  pipe_flush,
   output logic [IW-1:0]         pipe_flush_id,
   output logic [GW-1:0]         pipe_src
);

   logic [AW-1:0]      r_addr;
   logic [IW-1:0]      r_id;
   logic [GW-1:0]      r_src;
   logic               r_valid;
   logic [GW-1:0]      r_last;

   logic               w_flush_hit;
   logic               w_free;
   logic [NUM_REQ-1:0] w_elig;
   logic               w_found;
   logic [GW-1:0]      w_win;
   logic [NUM_REQ-1:0] w_ready;

   assign w_flush_hit = flush_in && r_valid && (r_id == flush_id_in);
   assign w_free      = !r_valid || !pipe_stall || w_flush_hit;

   // Requesters carrying the ID being flushed this cycle are masked out
   always_comb begin
      w_elig = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_elig[k] = req_valid[k] && !(flush_in && (req_id[k*IW +: IW] == flush_id_in));
      end
   end

   always_comb begin
      int idx;
      w_found = 1'b0;
      w_win   = '0;
      idx     = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(r_last) + i) % NUM_REQ;
         if (!w_found && w_elig[idx]) begin
            w_found = 1'b1;
            w_win   = GW'(idx);
         end
      end
   end

   always_comb begin
      w_ready = '0;
      if (reset && w_free && w_found) begin
         w_ready[w_win] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_id    <= '0;
         r_src   <= '0;
         r_last  <= GW'(NUM_REQ - 1);
      end else if (w_free) begin
         if (w_found) begin
            r_valid <= 1'b1;
            r_addr  <= req_address[int'(w_win)*AW +: AW];
            r_id    <= req_id[int'(w_win)*IW +: IW];
            r_src   <= w_win;
            r_last  <= w_win;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign req_ready     = w_ready;
   assign pipe_address  = r_addr;
   assign pipe_id       = r_id;
   assign pipe_src      = r_src;
   assign pipe_valid    = r_valid;
   assign pipe_flush    = flush_in;
   assign pipe_flush_id = flush_id_in;

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Directed bench for pipeline_arbiter: stimulus pushes hand-computed accepted
// entries into a scoreboard; a negedge monitor pops on every transfer or drop.
module tb_pipeline_arbiter;
   localparam int NUM_REQ = 4;
   localparam int AW      = 8;
   localparam int IW      = 4;
   localparam int GW      = 2;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NUM_REQ*AW-1:0] req_address;
   logic [NUM_REQ*IW-1:0] req_id;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  flush_in;
   logic [IW-1:0]         flush_id_in;
   logic [AW-1:0]         pipe_address;
   logic [IW-1:0]         pipe_id;
   logic                  pipe_valid;
   logic                  pipe_stall;
   logic                  pipe_flush;
   logic [IW-1:0]         pipe_flush_id;
   logic [GW-1:0]         pipe_src;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [IW-1:0] id;
      logic [GW-1:0] src;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   pipeline_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .IW(IW), .GW(GW)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_address  (req_address),
      .req_id       (req_id),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .flush_in     (flush_in),
      .flush_id_in  (flush_id_in),
      .pipe_address (pipe_address),
      .pipe_id      (pipe_id),
      .pipe_valid   (pipe_valid),
      .pipe_stall   (pipe_stall),
      .pipe_flush   (pipe_flush),
      .pipe_flush_id(pipe_flush_id),
      .pipe_src     (pipe_src)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pop(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got unexpected entry 0x%0h expected none at %0t", name,
                  {pipe_address, pipe_id, pipe_src}, $time);
      end else begin
         e = sb.pop_front();
         chk(name, 32'({pipe_address, pipe_id, pipe_src}), 32'(e));
      end
   endtask

   // Monitor: every held entry leaves by transfer, flush-drop or reset-drop
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (pipe_valid === 1'b1) pop("drop_rst");
      end else if (pipe_valid === 1'b1 && flush_in && pipe_id == flush_id_in && pipe_stall) begin
         pop("drop_flush");
      end else if (pipe_valid === 1'b1 && pipe_stall === 1'b0) begin
         pop("xfer");
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic set_req(input int k, input logic [AW-1:0] a, input logic [IW-1:0] id);
      req_address[k*AW +: AW] = a;
      req_id[k*IW +: IW]      = id;
      req_valid[k]            = 1'b1;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [GW-1:0] s);
      exp_t e;
      e.addr = a;
      e.id   = id;
      e.src  = s;
      sb.push_back(e);
   endtask

   initial begin
      reset       = 1'b0;
      req_address = '0;
      req_id      = '0;
      req_valid   = '0;
      flush_in    = 1'b0;
      flush_id_in = '0;
      pipe_stall  = 1'b0;

      // Reset: state cleared, no grants, flush still passes through
      cyc();
      for (int k = 0; k < NUM_REQ; k++) set_req(k, 8'(8'h20 + k), 4'(8 + k));
      flush_in = 1'b1; flush_id_in = 4'd6;
      smp();
      chk("rst_valid", 32'(pipe_valid), 32'd0);
      chk("rst_addr", 32'(pipe_address), 32'd0);
      chk("rst_id", 32'(pipe_id), 32'd0);
      chk("rst_src", 32'(pipe_src), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_flush", 32'(pipe_flush), 32'd1);
      chk("rst_flush_id", 32'(pipe_flush_id), 32'd6);

      // Round-robin over all four requesters
      cyc(); reset = 1'b1; flush_in = 1'b0;
      smp(); chk("rr0_ready", 32'(req_ready), 32'b0001); chk("rr0_pv", 32'(pipe_valid), 32'd0);
      push(8'h20, 4'd8, 2'd0);
      cyc(); smp(); chk("rr1_ready", 32'(req_ready), 32'b0010); chk("rr1_pv", 32'(pipe_valid), 32'd1);
      push(8'h21, 4'd9, 2'd1);
      cyc(); smp(); chk("rr2_ready", 32'(req_ready), 32'b0100); push(8'h22, 4'd10, 2'd2);
      cyc(); smp(); chk("rr3_ready", 32'(req_ready), 32'b1000); push(8'h23, 4'd11, 2'd3);
      cyc(); smp(); chk("rr4_ready", 32'(req_ready), 32'b0001); push(8'h20, 4'd8, 2'd0);
      cyc(); req_valid = '0;
      smp(); chk("bubble_ready", 32'(req_ready), 32'd0);
      cyc(); smp(); chk("bubble_pv", 32'(pipe_valid), 32'd0);

      // Stall holds req 2 entry for 3 cycles, transfer on the 4th
      cyc(); set_req(2, 8'h10, 4'd5);
      smp(); chk("st_load_ready", 32'(req_ready), 32'b0100); push(8'h10, 4'd5, 2'd2);
      cyc(); req_valid = '0; set_req(0, 8'h30, 4'd1); pipe_stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         smp();
         chk("st_ready", 32'(req_ready), 32'd0);
         chk("st_entry", 32'({pipe_valid, pipe_address, pipe_id, pipe_src}), {1'b1, 8'h10, 4'd5, 2'd2});
         if (c < 2) cyc();
      end
      cyc(); pipe_stall = 1'b0;
      smp(); chk("st_release_ready", 32'(req_ready), 32'b0001); push(8'h30, 4'd1, 2'd0);
      cyc(); req_valid = '0;
      cyc(); smp(); chk("st_end_pv", 32'(pipe_valid), 32'd0);

      // Flush of held id 7 under stall
      cyc(); set_req(1, 8'h40, 4'd7);
      smp(); chk("fl_load_ready", 32'(req_ready), 32'b0010); push(8'h40, 4'd7, 2'd1);
      cyc(); req_valid = '0; pipe_stall = 1'b1;
      cyc(); flush_in = 1'b1; flush_id_in = 4'd7;
      smp(); chk("fl_pipe_flush", 32'(pipe_flush), 32'd1); chk("fl_pipe_flush_id", 32'(pipe_flush_id), 32'd7);
      cyc(); flush_in = 1'b0; pipe_stall = 1'b0;
      smp(); chk("fl_pv", 32'(pipe_valid), 32'd0);

      // Flushed requester skipped: last_grant=0, req1 id3 masked, req3 wins
      cyc(); set_req(0, 8'h50, 4'd2);
      smp(); chk("fm_pre_ready", 32'(req_ready), 32'b0001); push(8'h50, 4'd2, 2'd0);
      cyc(); req_valid = '0; set_req(1, 8'h61, 4'd3); set_req(3, 8'h63, 4'd9);
      flush_in = 1'b1; flush_id_in = 4'd3;
      smp(); chk("fm_ready", 32'(req_ready), 32'b1000); push(8'h63, 4'd9, 2'd3);
      cyc(); flush_in = 1'b0; req_valid = '0;
      smp(); chk("fm_src", 32'(pipe_src), 32'd3);
      cyc();

      // Wrap: last_grant=3, only req3 -> req3; then req0+req3 -> req0
      cyc(); set_req(3, 8'h73, 4'hA);
      smp(); chk("wr_ready3", 32'(req_ready), 32'b1000); push(8'h73, 4'hA, 2'd3);
      cyc(); set_req(0, 8'h70, 4'hB);
      smp(); chk("wr_ready0", 32'(req_ready), 32'b0001); push(8'h70, 4'hB, 2'd0);
      cyc(); req_valid = '0;
      cyc();

      // Flush-drop and new accept in the same cycle
      cyc(); set_req(2, 8'h80, 4'd4);
      smp(); chk("fa_load_ready", 32'(req_ready), 32'b0100); push(8'h80, 4'd4, 2'd2);
      cyc(); req_valid = '0; pipe_stall = 1'b1;
      cyc(); flush_in = 1'b1; flush_id_in = 4'd4; set_req(1, 8'h81, 4'd6);
      smp(); chk("fa_ready", 32'(req_ready), 32'b0010); push(8'h81, 4'd6, 2'd1);
      cyc(); flush_in = 1'b0; req_valid = '0;
      smp(); chk("fa_entry", 32'({pipe_valid, pipe_id, pipe_src}), {1'b1, 4'd6, 2'd1});
      cyc(); pipe_stall = 1'b0;
      cyc(); smp(); chk("fa_end_pv", 32'(pipe_valid), 32'd0);

      // Reset while an entry is held under stall
      cyc(); set_req(3, 8'h90, 4'hC);
      smp(); chk("rs_load_ready", 32'(req_ready), 32'b1000); push(8'h90, 4'hC, 2'd3);
      cyc(); req_valid = '0; pipe_stall = 1'b1;
      cyc(); reset = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) set_req(k, 8'(8'hA0 + k), 4'(k));
      smp(); chk("rs_ready_a", 32'(req_ready), 32'd0);
      cyc(); smp(); chk("rs_pv", 32'(pipe_valid), 32'd0); chk("rs_ready_b", 32'(req_ready), 32'd0);
      cyc(); reset = 1'b1; pipe_stall = 1'b0;
      smp(); chk("rs_after_ready", 32'(req_ready), 32'b0001); push(8'hA0, 4'd0, 2'd0);
      cyc(); req_valid = '0;
      cyc(); cyc();
      smp(); chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
